// File: rtl/segment_histogram.sv
// segment_histogram
//   Accumulates how often each segment number (0..3) occurs over a window of
//   WINDOW accepted samples, then publishes the four counts and the index of
//   the most frequent segment (lowest index on a tie).
//
// Parameters
//   WINDOW             accepted samples per window, 1..255
// Ports
//   in_clock           system clock, rising edge
//   in_reset           asynchronous active-high reset
//   in_start           one-cycle pulse, opens (or restarts) a window
//   in_valid           in_segment_number carries a sample this cycle
//   in_segment_number  chosen segment, 0..3
//   out_weight0..3     per-segment counts of the last completed window
//   out_max_segment    argmax of the last completed window
//   out_done           one-cycle pulse, new results valid
//   out_busy           high while a window is open or finishing
module segment_histogram #(
    parameter int WINDOW = 8
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_start,
    input  logic       in_valid,
    input  logic [1:0] in_segment_number,
    output logic [7:0] out_weight0,
    output logic [7:0] out_weight1,
    output logic [7:0] out_weight2,
    output logic [7:0] out_weight3,
    output logic [1:0] out_max_segment,
    output logic       out_done,
    output logic       out_busy
);

    localparam logic [7:0] LP_WINDOW = 8'(WINDOW);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0][7:0] r_cnt;
    logic [7:0]      r_n;

    logic [7:0]      w_n_inc;
    logic [7:0]      w_best;
    logic [1:0]      w_max;

    assign w_n_inc = r_n + 8'd1;

    // Strict greater-than keeps the earliest (lowest) index on ties.
    always_comb begin
        w_best = r_cnt[0];
        w_max  = 2'd0;
        for (int unsigned i = 1; i < 4; i++) begin
            if (r_cnt[i] > w_best) begin
                w_best = r_cnt[i];
                w_max  = 2'(i);
            end
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_n             <= '0;
            out_weight0     <= '0;
            out_weight1     <= '0;
            out_weight2     <= '0;
            out_weight3     <= '0;
            out_max_segment <= '0;
            out_done        <= 1'b0;
            out_busy        <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_start) begin
                        r_cnt    <= '0;
                        r_n      <= '0;
                        r_state  <= ST_COUNT;
                        out_busy <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (in_start) begin
                        // Restart: the simultaneous sample is dropped.
                        r_cnt <= '0;
                        r_n   <= '0;
                    end else if (in_valid) begin
                        r_cnt[in_segment_number] <= r_cnt[in_segment_number] + 8'd1;
                        r_n <= w_n_inc;
                        if (w_n_inc == LP_WINDOW) begin
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    out_weight0     <= r_cnt[0];
                    out_weight1     <= r_cnt[1];
                    out_weight2     <= r_cnt[2];
                    out_weight3     <= r_cnt[3];
                    out_max_segment <= w_max;
                    out_done        <= 1'b1;
                    out_busy        <= 1'b0;
                    r_state         <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    out_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segment_histogram.sv
// Bench for segment_histogram: four instances (WINDOW = 8, 4, 255, 1) share
// clock and reset; expected window results go into a scoreboard queue and a
// monitor compares them whenever an instance pulses out_done.
module tb_segment_histogram;

    logic       clk;
    logic       rst;
    logic       start [4];
    logic       valid [4];
    logic [1:0] seg   [4];
    logic [7:0] w0    [4];
    logic [7:0] w1    [4];
    logic [7:0] w2    [4];
    logic [7:0] w3    [4];
    logic [1:0] mx    [4];
    logic       done  [4];
    logic       busy  [4];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]      id;
        logic [3:0][7:0] w;
        logic [1:0]      mx;
    } exp_t;

    exp_t sb[$];

    segment_histogram #(.WINDOW(8)) u_w8 (
        .in_clock(clk), .in_reset(rst), .in_start(start[0]), .in_valid(valid[0]),
        .in_segment_number(seg[0]), .out_weight0(w0[0]), .out_weight1(w1[0]),
        .out_weight2(w2[0]), .out_weight3(w3[0]), .out_max_segment(mx[0]),
        .out_done(done[0]), .out_busy(busy[0]));

    segment_histogram #(.WINDOW(4)) u_w4 (
        .in_clock(clk), .in_reset(rst), .in_start(start[1]), .in_valid(valid[1]),
        .in_segment_number(seg[1]), .out_weight0(w0[1]), .out_weight1(w1[1]),
        .out_weight2(w2[1]), .out_weight3(w3[1]), .out_max_segment(mx[1]),
        .out_done(done[1]), .out_busy(busy[1]));

    segment_histogram #(.WINDOW(255)) u_w255 (
        .in_clock(clk), .in_reset(rst), .in_start(start[2]), .in_valid(valid[2]),
        .in_segment_number(seg[2]), .out_weight0(w0[2]), .out_weight1(w1[2]),
        .out_weight2(w2[2]), .out_weight3(w3[2]), .out_max_segment(mx[2]),
        .out_done(done[2]), .out_busy(busy[2]));

    segment_histogram #(.WINDOW(1)) u_w1 (
        .in_clock(clk), .in_reset(rst), .in_start(start[3]), .in_valid(valid[3]),
        .in_segment_number(seg[3]), .out_weight0(w0[3]), .out_weight1(w1[3]),
        .out_weight2(w2[3]), .out_weight3(w3[3]), .out_max_segment(mx[3]),
        .out_done(done[3]), .out_busy(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int a, input int b, input int c,
                        input int e, input int m);
        exp_t x;
        x.id   = 2'(d);
        x.w[0] = 8'(a);
        x.w[1] = 8'(b);
        x.w[2] = 8'(c);
        x.w[3] = 8'(e);
        x.mx   = 2'(m);
        sb.push_back(x);
    endtask

    task automatic start_pulse(input int d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    task automatic sample(input int d, input int s);
        valid[d] = 1'b1;
        seg[d]   = 2'(s);
        tick();
        valid[d] = 1'b0;
    endtask

    task automatic chk_zero(input string nm, input int d);
        chk({nm, "_w0"}, int'(w0[d]), 0);
        chk({nm, "_w1"}, int'(w1[d]), 0);
        chk({nm, "_w2"}, int'(w2[d]), 0);
        chk({nm, "_w3"}, int'(w3[d]), 0);
        chk({nm, "_max"}, int'(mx[d]), 0);
        chk({nm, "_done"}, int'(done[d]), 0);
        chk({nm, "_busy"}, int'(busy[d]), 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (done[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", d, -1);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("sb_id", d, int'(x.id));
                    chk("sb_w0", int'(w0[d]), int'(x.w[0]));
                    chk("sb_w1", int'(w1[d]), int'(x.w[1]));
                    chk("sb_w2", int'(w2[d]), int'(x.w[2]));
                    chk("sb_w3", int'(w3[d]), int'(x.w[3]));
                    chk("sb_max", int'(mx[d]), int'(x.mx));
                end
            end
        end
    end

    initial begin
        int seq_a[8];
        int seq_t[4];
        seq_a = '{0, 1, 1, 2, 3, 3, 3, 3};
        seq_t = '{2, 1, 2, 1};
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            start[d] = 1'b0;
            valid[d] = 1'b0;
            seg[d]   = 2'd0;
        end
        tick();
        tick();
        chk_zero("reset", 0);
        chk_zero("reset_w1", 3);
        rst = 1'b0;
        tick();

        // Basic window
        push(0, 1, 2, 1, 4, 3);
        start_pulse(0);
        chk("basic_busy_start", int'(busy[0]), 1);
        for (int i = 0; i < 8; i++) sample(0, seq_a[i]);
        chk("basic_finish_done", int'(done[0]), 0);
        chk("basic_finish_busy", int'(busy[0]), 1);
        tick();
        chk("basic_done", int'(done[0]), 1);
        chk("basic_busy_fall", int'(busy[0]), 0);
        chk("basic_w3", int'(w3[0]), 4);
        tick();
        chk("basic_done_1cyc", int'(done[0]), 0);

        // Gaps and ignored samples
        push(0, 1, 2, 1, 4, 3);
        valid[0] = 1'b1; seg[0] = 2'd0;
        tick();
        chk("gap_idle_busy", int'(busy[0]), 0);
        start[0] = 1'b1; seg[0] = 2'd3;
        tick();
        start[0] = 1'b0; valid[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample(0, seq_a[i]);
            if (i != 7) tick();
        end
        chk("gap_finish_done", int'(done[0]), 0);
        valid[0] = 1'b1; seg[0] = 2'd0; start[0] = 1'b1;
        tick();
        chk("gap_done", int'(done[0]), 1);
        chk("gap_busy", int'(busy[0]), 0);
        valid[0] = 1'b0; start[0] = 1'b0;
        tick();
        chk("gap_start_in_finish_ignored", int'(busy[0]), 0);
        chk("gap_done_1cyc", int'(done[0]), 0);

        // Restart mid-window
        push(0, 0, 8, 0, 0, 1);
        start_pulse(0);
        for (int i = 0; i < 5; i++) sample(0, 2);
        valid[0] = 1'b1; seg[0] = 2'd2;
        start_pulse(0);
        valid[0] = 1'b0;
        chk("restart_busy", int'(busy[0]), 1);
        chk("restart_hold_w2", int'(w2[0]), 1);
        chk("restart_hold_max", int'(mx[0]), 3);
        for (int i = 0; i < 8; i++) sample(0, 1);
        chk("restart_hold_w1", int'(w1[0]), 2);
        chk("restart_hold_w3", int'(w3[0]), 4);
        tick();
        chk("restart_done", int'(done[0]), 1);
        chk("restart_w1", int'(w1[0]), 8);
        tick();

        // Tie, WINDOW=4
        push(1, 0, 2, 2, 0, 1);
        start_pulse(1);
        for (int i = 0; i < 4; i++) sample(1, seq_t[i]);
        tick();
        chk("tie_done", int'(done[1]), 1);
        chk("tie_max", int'(mx[1]), 1);
        tick();

        // WINDOW=255, all segment 0
        push(2, 255, 0, 0, 0, 0);
        start_pulse(2);
        for (int i = 0; i < 255; i++) sample(2, 0);
        chk("w255_finish_done", int'(done[2]), 0);
        chk("w255_finish_busy", int'(busy[2]), 1);
        tick();
        chk("w255_done", int'(done[2]), 1);
        chk("w255_w0", int'(w0[2]), 255);
        tick();

        // WINDOW=1
        push(3, 0, 0, 1, 0, 2);
        start_pulse(3);
        sample(3, 2);
        chk("w1_finish_done", int'(done[3]), 0);
        tick();
        chk("w1_done", int'(done[3]), 1);
        chk("w1_w2", int'(w2[3]), 1);
        tick();

        // Reset mid-window
        start_pulse(0);
        for (int i = 0; i < 3; i++) sample(0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_async", 0);
        chk_zero("rst_async_w255", 2);
        tick();
        tick();
        tick();
        chk_zero("rst_hold", 0);
        rst = 1'b0;
        tick();
        push(0, 0, 0, 0, 8, 3);
        start_pulse(0);
        for (int i = 0; i < 8; i++) sample(0, 3);
        tick();
        chk("post_rst_done", int'(done[0]), 1);
        chk("post_rst_w3", int'(w3[0]), 8);
        tick();
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segment_histogram.md
# segment_histogram

Sample-side counterpart to the weighted segment chooser. It consumes the stream of chosen segment numbers (0–3) and accumulates a per-segment occurrence count over a fixed window of accepted samples. At the end of each window it publishes the four counts as 8-bit weights, plus the index of the most frequent segment. It sits downstream of the chooser in the MCMC solver: it checks the chooser's empirical distribution against the programmed weights, and it can feed measured weights back as new chooser weights.

## Interface
Parameters:
- WINDOW, 8: number of accepted samples per window; legal range 1..255.

Ports:
- in_clock  input  1  main system clock; all state updates on its rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_start  input  1  one-cycle pulse that opens a new window.
- in_valid  input  1  in_segment_number carries a sample this cycle.
- in_segment_number  input  2  chosen segment, 0..3.
- out_weight0  output  8  count of segment 0 in the last completed window.
- out_weight1  output  8  count of segment 1 in the last completed window.
- out_weight2  output  8  count of segment 2 in the last completed window.
- out_weight3  output  8  count of segment 3 in the last completed window.
- out_max_segment  output  2  segment with the highest count in the last completed window.
- out_done  output  1  one-cycle pulse; new results are valid.
- out_busy  output  1  high while a window is open or finishing.

## Operation
- States: IDLE, COUNT, FINISH.
- Internal registers:
  - four 8-bit counters cnt0..cnt3;
  - 8-bit sample counter n.
- IDLE:
  - in_valid is ignored.
  - in_start=1 clears cnt0..3 and n, then moves to COUNT.
  - The sample presented in the start cycle is not counted.
- COUNT:
  - in_valid=1 increments cnt[in_segment_number] and n.
  - When this increment makes n equal WINDOW, move to FINISH.
  - in_start=1 in COUNT restarts the window: cnt0..3 and n are cleared, the state stays COUNT, and the simultaneous sample is dropped. Published outputs are untouched.
- FINISH (exactly one cycle):
  - in_valid and in_start are ignored.
  - out_weightN is loaded from cntN.
  - out_max_segment is loaded with the argmax of cnt0..3; on a tie the lowest index wins.
  - out_done is set for one cycle; the state returns to IDLE.
- out_busy = (state != IDLE), registered with the state.
- Width rules:
  - WINDOW ≤ 255, so no counter can overflow.
  - After every completed window, out_weight0+out_weight1+out_weight2+out_weight3 = WINDOW exactly.
- Published outputs hold their values until the next FINISH or reset.
- Reset (asynchronous, any state, including mid-window):
  - state goes to IDLE;
  - cnt0..3, n, out_weight0..3, out_max_segment, out_done and out_busy all go to 0.
  - After reset deasserts, the first in_start behaves normally.

## Timing
- in_start sampled at edge E0 → out_busy=1 after E0; counting begins with samples at edge E0+1.
- Last accepted sample at edge Ek → FINISH during cycle Ek..Ek+1.
- At edge Ek+1: outputs update, out_done=1 for cycle Ek+1..Ek+2, out_busy=0.
- Latency from last sample to results: 1 edge.
- Minimum window duration: WINDOW+2 cycles from in_start to out_done.
- in_start in the same cycle as out_done (state IDLE) is accepted; back-to-back windows are allowed.
- in_valid may be low for any number of cycles; gaps only stretch the window.

## Test plan
- Reset: assert in_reset asynchronously mid-cycle → all outputs 0 immediately, out_busy=0; hold 3 cycles → still 0.
- Basic window, WINDOW=8: pulse start, then samples 0,1,1,2,3,3,3,3 on consecutive cycles → one edge after the last sample: weights 1,2,1,4; out_max_segment=3; out_done high exactly 1 cycle; out_busy falls at the same edge.
- Gaps and ignored samples, WINDOW=8: in_valid toggling 1/0, plus valid samples sent in IDLE and in FINISH → only the 8 samples in COUNT counted; result identical to the basic case; out_done 1 edge after the 8th counted sample.
- Restart: after 5 counted samples of segment 2, pulse in_start, then 8 samples of segment 1 → weights 0,8,0,0, out_max_segment=1. The previous window's outputs stay held until that out_done.
- Tie and extremes:
  - WINDOW=4, samples 2,1,2,1 → weights 0,2,2,0, out_max_segment=1.
  - WINDOW=255, all samples segment 0 → weight0=255, others 0, out_max_segment=0.
  - WINDOW=1 → out_done one edge after the single sample.
- Reset mid-window: after 3 samples, assert in_reset → everything is 0. After release, a full window of 8 samples of segment 3 gives weights 0,0,0,8 (no residue from before the reset).
